arbiter: RTL and testbench
==========================

ARBITER -- requirements
Module: arbiter

Interface
REQ-001 Parameter PORTS, default 4: number of requesters; legal range 2..32.
REQ-002 Parameter ARB_TYPE_ROUND_ROBIN, default 1: 1 = round-robin, 0 = fixed priority.
REQ-003 Parameter ARB_BLOCK, default 1: 1 = hold grant until released, 0 = re-arbitrate every cycle.
REQ-004 Parameter ARB_BLOCK_ACK, default 1: with ARB_BLOCK=1, 1 = release on acknowledge, 0 = release when the granted request drops.
REQ-005 Parameter ARB_LSB_HIGH_PRIORITY, default 0: 1 = bit 0 highest priority, 0 = bit PORTS-1 highest priority.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 request  input  PORTS  per-port request, level-sensitive.
REQ-009 acknowledge  input  PORTS  per-port release strobe; only the currently granted bit is meaningful.
REQ-010 grant  output  PORTS  one-hot grant, registered.
REQ-011 grant_valid  output  1  high when grant is nonzero, registered.
REQ-012 grant_encoded  output  $clog2(PORTS)  binary index of granted port, registered.

Function
REQ-013 Outputs SHALL be registered: grant, grant_valid and grant_encoded change only on a clk edge, one cycle after the request or acknowledge change that causes them.
REQ-014 grant SHALL always be zero or one-hot, SHALL equal 1 << grant_encoded when grant_valid=1, and SHALL be zero when grant_valid=0.
REQ-015 Hold conditions are checked in this order; the first match wins:
- ARB_BLOCK=1, ARB_BLOCK_ACK=0, and (grant & request) nonzero: hold.
- ARB_BLOCK=1, ARB_BLOCK_ACK=1, grant_valid=1, and (grant & acknowledge) zero: hold.
- Otherwise: a new arbitration takes place.
REQ-016 New arbitration, fixed priority: grant the highest-priority set bit of request.
REQ-017 New arbitration, round-robin: grant the highest-priority set bit of (request & mask) if that is nonzero; otherwise grant the highest-priority set bit of request.
REQ-018 Mask update after a grant to index k:
- ARB_LSB_HIGH_PRIORITY=0: mask = bits below k.
- ARB_LSB_HIGH_PRIORITY=1: mask = bits above k.
REQ-019 When a new arbitration finds request==0, the next state SHALL be grant=0, grant_valid=0, grant_encoded=0; mask is unchanged.
REQ-020 Acknowledge and a new request in the same cycle: arbitration SHALL use that cycle's request, so a grant can move port to port with no idle cycle.
REQ-021 While a grant is held, acknowledge bits of non-granted ports SHALL be ignored.
REQ-022 A granted port that drops its request while ARB_BLOCK_ACK=1 SHALL keep its grant until acknowledged.
REQ-023 The granted port may be re-granted right after release only if no other request is enabled by the mask.

Reset
REQ-024 Asserting rst SHALL immediately (without a clock edge) set grant=0, grant_valid=0, grant_encoded=0 and mask=0.
REQ-025 Reset mid-grant SHALL discard the hold; the first edge after deassertion performs a fresh arbitration with mask=0.

Structure
REQ-026 Priority selection SHALL use two instances of the existing priority_encoder sub-module, one for request and one for request & mask. WIDTH=PORTS and LSB_HIGH_PRIORITY=ARB_LSB_HIGH_PRIORITY are passed through.
REQ-027 No shared package is needed. Widths derive locally from PORTS; the next-state logic is combinational, and only grant, grant_valid, grant_encoded and mask are registered.

Verification (PORTS=4, ARB_LSB_HIGH_PRIORITY=0 unless stated)
REQ-028 Reset: rst=1 with request=4'b1111 -> grant=0 and grant_valid=0 immediately; after release, next edge -> grant=4'b1000, grant_encoded=3.
REQ-029 Round-robin: request=4'b0101 held, acknowledge pulsed on each grant -> grant sequence 4'b0100, 4'b0001, 4'b0100, 4'b0001.
REQ-030 Blocking: grant=4'b0010, request=4'b1010, acknowledge=0 for 5 cycles -> grant stays 4'b0010; acknowledge=4'b0010 -> next grant 4'b1000.
REQ-031 Stray acknowledge: grant=4'b0100, acknowledge=4'b1011 -> grant stays 4'b0100.
REQ-032 Fixed priority: ARB_TYPE_ROUND_ROBIN=0, ARB_BLOCK=0, request=4'b0011 steady -> grant=4'b0010 every cycle. Then request=0 -> next cycle grant=0 and grant_valid=0.
REQ-033 Request-drop release: ARB_BLOCK_ACK=0, ARB_LSB_HIGH_PRIORITY=1, request=4'b0110 -> grant=4'b0010. Then request=4'b0100 -> next cycle grant=4'b0100.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types for the arbiter: the per-cycle decision taken by the next-state logic.
package arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_DECIDE_NEW   = 2'd0,
    ARB_HOLD_REQUEST = 2'd1,
    ARB_HOLD_ACK     = 2'd2
  } arb_action_e;

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder: index and one-hot of the highest-priority set bit.
module priority_encoder #(
  parameter int WIDTH             = 4,
  parameter int LSB_HIGH_PRIORITY = 0,
  localparam int IW               = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  output logic             valid,
  output logic [IW-1:0]    index,
  output logic [WIDTH-1:0] onehot
);

  always_comb begin
    index = '0;
    // Later iterations overwrite earlier ones, so the loop order sets the priority.
    for (int i = 0; i < WIDTH; i++) begin
      if (LSB_HIGH_PRIORITY != 0) begin
        if (value[WIDTH-1-i]) index = IW'(WIDTH - 1 - i);
      end else begin
        if (value[i]) index = IW'(i);
      end
    end
    valid  = |value;
    onehot = valid ? (WIDTH'(1) << index) : '0;
  end

endmodule

// File: rtl/arbiter.sv
// Parameterised round-robin / fixed-priority arbiter with optional blocking grants.
module arbiter
  import arbiter_pkg::*;
#(
  parameter int PORTS                 = 4,
  parameter int ARB_TYPE_ROUND_ROBIN  = 1,
  parameter int ARB_BLOCK             = 1,
  parameter int ARB_BLOCK_ACK         = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 0,
  localparam int IW                   = $clog2(PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_encoded
);

  logic [PORTS-1:0] mask;
  logic [PORTS-1:0] grant_next;
  logic             grant_valid_next;
  logic [IW-1:0]    grant_encoded_next;
  logic [PORTS-1:0] mask_next;
  arb_action_e      action;

  logic             req_valid;
  logic [IW-1:0]    req_index;
  logic [PORTS-1:0] req_onehot;
  logic             masked_valid;
  logic [IW-1:0]    masked_index;
  logic [PORTS-1:0] masked_onehot;

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_pe_request (
    .value  (request),
    .valid  (req_valid),
    .index  (req_index),
    .onehot (req_onehot)
  );

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_pe_masked (
    .value  (request & mask),
    .valid  (masked_valid),
    .index  (masked_index),
    .onehot (masked_onehot)
  );

  always_comb begin
    action             = ARB_DECIDE_NEW;
    grant_next         = grant;
    grant_valid_next   = grant_valid;
    grant_encoded_next = grant_encoded;
    mask_next          = mask;

    if (ARB_BLOCK != 0 && ARB_BLOCK_ACK == 0 && |(grant & request)) begin
      action = ARB_HOLD_REQUEST;
    end else if (ARB_BLOCK != 0 && ARB_BLOCK_ACK != 0 && grant_valid && !(|(grant & acknowledge))) begin
      action = ARB_HOLD_ACK;
    end

    if (action == ARB_DECIDE_NEW) begin
      if (ARB_TYPE_ROUND_ROBIN != 0 && masked_valid) begin
        grant_next         = masked_onehot;
        grant_encoded_next = masked_index;
        grant_valid_next   = 1'b1;
      end else if (req_valid) begin
        grant_next         = req_onehot;
        grant_encoded_next = req_index;
        grant_valid_next   = 1'b1;
      end else begin
        grant_next         = '0;
        grant_encoded_next = '0;
        grant_valid_next   = 1'b0;
      end
      // Mask keeps only ports ranked below the winner so they go first next time.
      if (grant_valid_next) begin
        if (ARB_LSB_HIGH_PRIORITY != 0) begin
          mask_next = ~(grant_next | (grant_next - PORTS'(1)));
        end else begin
          mask_next = grant_next - PORTS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      mask          <= '0;
    end else begin
      grant         <= grant_next;
      grant_valid   <= grant_valid_next;
      grant_encoded <= grant_encoded_next;
      mask          <= mask_next;
    end
  end

endmodule

// File: tb/tb_arbiter.sv
// Directed bench for arbiter: round-robin blocking, fixed-priority and request-drop variants.
module tb_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_rr, ack_rr, grant_rr;
  logic       valid_rr;
  logic [1:0] enc_rr;
  logic [3:0] req_fp, ack_fp, grant_fp;
  logic       valid_fp;
  logic [1:0] enc_fp;
  logic [3:0] req_dr, ack_dr, grant_dr;
  logic       valid_dr;
  logic [1:0] enc_dr;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  arbiter u_rr (
    .clk (clk), .rst (rst), .request (req_rr), .acknowledge (ack_rr),
    .grant (grant_rr), .grant_valid (valid_rr), .grant_encoded (enc_rr)
  );

  arbiter #(.ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0)) u_fp (
    .clk (clk), .rst (rst), .request (req_fp), .acknowledge (ack_fp),
    .grant (grant_fp), .grant_valid (valid_fp), .grant_encoded (enc_fp)
  );

  arbiter #(.ARB_BLOCK_ACK(0), .ARB_LSB_HIGH_PRIORITY(1)) u_dr (
    .clk (clk), .rst (rst), .request (req_dr), .acknowledge (ack_dr),
    .grant (grant_dr), .grant_valid (valid_dr), .grant_encoded (enc_dr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one edge and settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rr(input string tag, input logic [3:0] g, input logic [1:0] e);
    check({tag, "_grant"}, 32'(grant_rr), 32'(g));
    check({tag, "_valid"}, 32'(valid_rr), 32'(g != 4'b0000));
    check({tag, "_enc"}, 32'(enc_rr), 32'(e));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [3:0] exp_g;

  initial begin
    rst = 1'b1;
    req_rr = 4'b1111; ack_rr = '0;
    req_fp = '0;      ack_fp = '0;
    req_dr = '0;      ack_dr = '0;

    // Reset is immediate, then MSB wins from mask=0.
    #1;
    check_rr("reset_async", 4'b0000, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check_rr("reset_first_arb", 4'b1000, 2'd3);

    // Round-robin over 0101 with an acknowledge on every grant.
    do_reset();
    req_rr = 4'b0101;
    exp_q.push_back(4'b0100); exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b0001);
    step();
    while (exp_q.size() > 0) begin
      exp_g = exp_q.pop_front();
      check_rr("rr_seq", exp_g, (exp_g == 4'b0100) ? 2'd2 : 2'd0);
      ack_rr = exp_g;
      if (exp_q.size() > 0) step();
    end
    ack_rr = '0;

    // Blocking: hold 0010 for five cycles without acknowledge.
    do_reset();
    req_rr = 4'b0010;
    step();
    check_rr("block_setup", 4'b0010, 2'd1);
    req_rr = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      step();
      check_rr("block_hold", 4'b0010, 2'd1);
    end
    ack_rr = 4'b0010;
    step();
    check_rr("block_release", 4'b1000, 2'd3);
    ack_rr = '0;

    // Granted port drops request but keeps grant until acknowledged.
    req_rr = 4'b0000;
    step();
    check_rr("drop_keeps_grant", 4'b1000, 2'd3);
    ack_rr = 4'b1000;
    step();
    check_rr("idle_after_ack", 4'b0000, 2'd0);
    ack_rr = '0;

    // Stray acknowledges on non-granted ports are ignored.
    req_rr = 4'b0100;
    step();
    check_rr("stray_setup", 4'b0100, 2'd2);
    ack_rr = 4'b1011;
    step();
    check_rr("stray_ack", 4'b0100, 2'd2);

    // Sole requester is re-granted right after release.
    ack_rr = 4'b0100;
    step();
    check_rr("regrant_sole", 4'b0100, 2'd2);
    ack_rr = '0;

    // Reset mid-grant clears mask: 1001 must pick bit 3, not bit 0.
    req_rr = 4'b1001;
    rst = 1'b1;
    #1;
    check_rr("reset_mid_grant", 4'b0000, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check_rr("reset_fresh_arb", 4'b1000, 2'd3);

    // Fixed priority, non-blocking.
    req_fp = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fp_grant", 32'(grant_fp), 32'h2);
      check("fp_enc", 32'(enc_fp), 32'd1);
    end
    req_fp = 4'b0000;
    step();
    check("fp_idle_grant", 32'(grant_fp), 32'h0);
    check("fp_idle_valid", 32'(valid_fp), 32'd0);

    // Release on request drop, LSB highest priority.
    req_dr = 4'b0110;
    step();
    check("dr_first", 32'(grant_dr), 32'h2);
    check("dr_enc", 32'(enc_dr), 32'd1);
    req_dr = 4'b0100;
    step();
    check("dr_move", 32'(grant_dr), 32'h4);
    req_dr = 4'b0110;
    step();
    check("dr_hold", 32'(grant_dr), 32'h4);
    check("dr_hold_valid", 32'(valid_dr), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
